instr_mem_multi: RTL and testbench
==================================

// Module: instr_mem_multi
// PURPOSE
//  Parametrised instruction store for the matrix-multiply processor(s). N_PORTS independent
//  registered fetch ports; a streaming valid/ready loader writes a program at run time.
//  Tracks program length; fetches at or beyond it return NOP. Sits between host/loader and core fetch.
// PARAMETERS
//  DATA_WIDTH  8   instruction/operand word width (bits)
//  ADDR_WIDTH  8   address width; depth = 2**ADDR_WIDTH words
//  N_PORTS     2   number of core fetch ports (1..4)
// PORTS
//  clk          in   1                   clock, all logic posedge
//  rst          in   1                   asynchronous, active-high reset
//  load_start   in   1                   pulse: begin new program load at address 0
//  load_valid   in   1                   loader word valid
//  load_ready   out  1                   loader word accepted when valid&ready
//  load_data    in   DATA_WIDTH          program word
//  load_last    in   1                   marks final word of program
//  load_done    out  1                   1-cycle pulse: program committed
//  load_err     out  1                   sticky: overflow on last load; cleared by load_start
//  prog_len     out  ADDR_WIDTH+1        committed program length in words
//  fetch_en     in   N_PORTS             per-port read request
//  fetch_addr   in   N_PORTS*ADDR_WIDTH  per-port address, port p at [p*AW +: AW]
//  fetch_instr  out  N_PORTS*DATA_WIDTH  per-port registered read data
//  fetch_valid  out  N_PORTS             fetch_instr valid this cycle
//  parity_err   out  N_PORTS             (IMEM_PARITY_EN only, else tied 0) parity mismatch
// BEHAVIOUR
//  Reset: state IDLE; load_ready=0, load_done=0, load_err=0, prog_len=0, fetch_valid=0,
//   fetch_instr=0, parity_err=0. Memory array not reset; contents undefined after reset.
//  FSM IDLE->LOAD on load_start (wr_ptr<=0, load_err<=0); LOAD->COMMIT on accepted beat
//   with load_last or with wr_ptr==2**AW-1 (sets load_err if load_last=0); COMMIT->IDLE after 1 cycle.
//  load_ready=1 only in LOAD. Accepted beat writes mem[wr_ptr], wr_ptr++ (no wrap).
//  COMMIT: prog_len<=wr_ptr count (words written, up to 2**AW), load_done=1 for that cycle.
//  load_start in LOAD or COMMIT is ignored. prog_len keeps old value during LOAD.
//  Fetch: latency 1. fetch_en[p] at cycle t -> fetch_valid[p]=1, fetch_instr[p] at t+1.
//   Address >= prog_len returns NOP_OP (34). fetch_en=0 -> fetch_valid=0, fetch_instr holds.
//  During LOAD/COMMIT fetch is stalled: fetch_valid=0, requests dropped (cores must be halted).
//  All ports read same array concurrently; same-address reads from all ports legal.
//  Reset mid-load: abort, prog_len=0, so all fetches return NOP until a new load commits.
// CONFIGURATION
//  IMEM_PARITY_EN defined: array stores DATA_WIDTH+1 bits (even parity generated on write);
//   read checks parity, parity_err[p] pulses with fetch_valid[p] on mismatch; data still returned.
//  Not defined: array DATA_WIDTH bits, parity_err tied 0, no check logic.
// STRUCTURE
//  Package instr_mem_pkg: opcode constants LDACI=0..NOP=34 (ENDOP=28, JPNZ=27), NOP_OP,
//   loader state encoding (ST_IDLE, ST_LOAD, ST_COMMIT).
//  Sub-module instr_mem_loader: FSM, wr_ptr, load_ready/done/err, prog_len; outputs we/waddr/wdata.
//  Top: array, write port, N_PORTS generate-loop read registers, bounds check, optional parity.
// TESTING
//  Load 3 words {0,5,28} with last on 3rd -> load_done pulse, prog_len=3, load_err=0.
//  Port0 addr1, port1 addr1 same cycle -> both fetch_valid next cycle, data 5; addr 3 -> 34.
//  load_valid toggled with gaps, 4 words -> only valid&ready beats written, prog_len=4.
//  AW=2, stream 5 words no last -> commit after 4th, prog_len=4, load_err=1, 5th not accepted.
//  rst asserted mid-load after 2 words -> prog_len=0, fetch any addr -> 34, load_ready=0.
//  IMEM_PARITY_EN: force bit flip in array via hierarchy -> parity_err[p]=1 with fetch_valid.

Source files
------------

// File: rtl/instr_mem_multi_pkg.sv
// Shared constants for the instruction memory: opcode values and loader state encoding.
package instr_mem_pkg;

  localparam int LDACI = 0;
  localparam int JPNZ  = 27;
  localparam int ENDOP = 28;
  localparam int NOP   = 34;

  // Word returned for any fetch at or beyond the committed program length.
  localparam int NOP_OP = NOP;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } load_state_t;

endpackage

// File: rtl/instr_mem_multi_if.sv
// Loader stream and per-port fetch bundle of the instruction memory.
interface instr_mem_multi_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int N_PORTS    = 2
);
  logic                           load_start;
  logic                           load_valid;
  logic                           load_ready;
  logic [DATA_WIDTH-1:0]          load_data;
  logic                           load_last;
  logic                           load_done;
  logic                           load_err;
  logic [ADDR_WIDTH:0]            prog_len;
  logic [N_PORTS-1:0]             fetch_en;
  logic [N_PORTS*ADDR_WIDTH-1:0]  fetch_addr;
  logic [N_PORTS*DATA_WIDTH-1:0]  fetch_instr;
  logic [N_PORTS-1:0]             fetch_valid;
  logic [N_PORTS-1:0]             parity_err;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_en, fetch_addr,
    input  load_ready, load_done, load_err, prog_len, fetch_instr, fetch_valid, parity_err
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_en, fetch_addr,
    output load_ready, load_done, load_err, prog_len, fetch_instr, fetch_valid, parity_err
  );
endinterface

// File: rtl/instr_mem_multi_loader.sv
// Program loader FSM: accepts a word stream from address 0, commits the length on the
// last word or when the array is full (overflow flagged if the stream had not ended).
//
// state     | meaning
// ST_IDLE   | no load in progress, fetch ports live
// ST_LOAD   | load_ready high, accepted beats written to mem[wr_ptr]
// ST_COMMIT | one cycle: load_done high, new prog_len visible
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  busy,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata
);

  load_state_t         state_q;
  logic [ADDR_WIDTH:0] wr_ptr;
  logic                last_slot;

  assign we        = load_ready & load_valid;
  assign waddr     = wr_ptr[ADDR_WIDTH-1:0];
  assign wdata     = load_data;
  assign busy      = (state_q != ST_IDLE);
  assign last_slot = &wr_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr     <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      prog_len   <= '0;
    end else begin
      load_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            state_q    <= ST_LOAD;
            wr_ptr     <= '0;
            load_err   <= 1'b0;
            load_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (we) begin
            wr_ptr <= wr_ptr + 1'b1;
            // Length committed together with load_done so both are seen in the same cycle.
            if (load_last || last_slot) begin
              state_q    <= ST_COMMIT;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
              load_err   <= ~load_last;
              prog_len   <= wr_ptr + 1'b1;
            end
          end
        end
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/instr_mem_multi.sv
// Multi-port instruction store with run-time loader; fetches beyond prog_len return NOP.
// IMEM_PARITY_EN adds an even-parity bit per word and a per-port parity_err pulse.
module instr_mem_multi
  import instr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int N_PORTS    = 2
) (
  input logic              clk,
  input logic              rst,
  instr_mem_multi_if.slave bus
);

`ifdef IMEM_PARITY_EN
  localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
  localparam int MEM_WIDTH = DATA_WIDTH;
`endif
  localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(NOP_OP);

  logic                          busy;
  logic                          we;
  logic [ADDR_WIDTH-1:0]         waddr;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [MEM_WIDTH-1:0]          wword;
  logic [MEM_WIDTH-1:0]          mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0]         rd_data [N_PORTS];
  logic [N_PORTS-1:0]            valid_q;
  logic [N_PORTS*DATA_WIDTH-1:0] instr_q;

  instr_mem_loader #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .load_start (bus.load_start),
    .load_valid (bus.load_valid),
    .load_data  (bus.load_data),
    .load_last  (bus.load_last),
    .load_ready (bus.load_ready),
    .load_done  (bus.load_done),
    .load_err   (bus.load_err),
    .prog_len   (bus.prog_len),
    .busy       (busy),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata)
  );

`ifdef IMEM_PARITY_EN
  logic               rd_perr [N_PORTS];
  logic [N_PORTS-1:0] perr_q;
  assign wword = {^wdata, wdata};
`else
  assign wword = wdata;
`endif

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wword;
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [MEM_WIDTH-1:0]  word;
    logic                  hit;
    assign addr       = bus.fetch_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign word       = mem[addr];
    assign hit        = ({1'b0, addr} < bus.prog_len);
    assign rd_data[p] = hit ? word[DATA_WIDTH-1:0] : NOP_WORD;
`ifdef IMEM_PARITY_EN
    assign rd_perr[p] = hit & (^word);
`endif
  end

  // Requests arriving while the loader owns the array are dropped, not deferred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      instr_q <= '0;
`ifdef IMEM_PARITY_EN
      perr_q  <= '0;
`endif
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (bus.fetch_en[p] && !busy) begin
          valid_q[p]                         <= 1'b1;
          instr_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_data[p];
`ifdef IMEM_PARITY_EN
          perr_q[p]                          <= rd_perr[p];
`endif
        end else begin
          valid_q[p] <= 1'b0;
`ifdef IMEM_PARITY_EN
          perr_q[p]  <= 1'b0;
`endif
        end
      end
    end
  end

  assign bus.fetch_valid = valid_q;
  assign bus.fetch_instr = instr_q;
`ifdef IMEM_PARITY_EN
  assign bus.parity_err  = perr_q;
`else
  assign bus.parity_err  = '0;
`endif

endmodule

// File: tb/tb_instr_mem_multi.sv
// Randomized bench for instr_mem_multi against an array/length reference model;
// a second instance with ADDR_WIDTH=2 covers the overflow commit.
module tb_instr_mem_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_mem_multi_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .N_PORTS(2)) bus1 ();
  instr_mem_multi_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .N_PORTS(2)) bus2 ();

  instr_mem_multi #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .N_PORTS(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  instr_mem_multi #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .N_PORTS(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  int n_checks = 0;
  int n_errors = 0;

  // reference model for dut1
  logic [7:0] mem1 [256];
  bit         bad1 [256];
  int         len1 = 0;
  logic [7:0] exp_instr1 [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch1(input logic [1:0] en, input logic [7:0] a0, input logic [7:0] a1);
    logic [7:0] a;
    logic       exp_perr;
    bus1.fetch_en   = en;
    bus1.fetch_addr = {a1, a0};
    tick();
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? a0 : a1;
      exp_perr = 1'b0;
      if (en[p]) begin
        exp_instr1[p] = (int'(a) < len1) ? mem1[a] : 8'd34;
        exp_perr = (int'(a) < len1) && bad1[a];
      end
      check_eq($sformatf("fetch_valid[%0d] a=%0d", p, a), 32'(bus1.fetch_valid[p]), 32'(en[p]));
      check_eq($sformatf("fetch_instr[%0d] a=%0d", p, a), 32'(bus1.fetch_instr[p*8 +: 8]),
               32'(exp_instr1[p]));
      check_eq($sformatf("parity_err[%0d]", p), 32'(bus1.parity_err[p]), 32'(exp_perr));
    end
    bus1.fetch_en = 2'b00;
  endtask

  task automatic rand_fetch1(input int n);
    logic [7:0] a0, a1;
    for (int i = 0; i < n; i++) begin
      a0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      a1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      fetch1(2'($urandom), a0, a1);
    end
  endtask

  task automatic load1(input logic [7:0] w [$], input bit gaps);
    int n;
    bus1.load_start = 1'b1;
    tick();
    bus1.load_start = 1'b0;
    check_eq("load_ready in LOAD", 32'(bus1.load_ready), 32'd1);
    for (int i = 0; i < w.size(); i++) begin
      n = gaps ? $urandom_range(0, 2) : 0;
      repeat (n) begin
        bus1.load_valid = 1'b0;
        bus1.load_start = 1'b1;
        bus1.fetch_en   = 2'b11;
        tick();
        check_eq("fetch stalled in LOAD", 32'(bus1.fetch_valid), 32'd0);
        check_eq("no done on gap", 32'(bus1.load_done), 32'd0);
      end
      bus1.load_start = 1'b0;
      bus1.fetch_en   = (i == w.size() - 1) ? 2'b00 : 2'b11;
      bus1.load_valid = 1'b1;
      bus1.load_data  = w[i];
      bus1.load_last  = (i == w.size() - 1);
      tick();
      mem1[i] = w[i];
      bad1[i] = 1'b0;
    end
    bus1.load_valid = 1'b0;
    bus1.load_last  = 1'b0;
    len1 = w.size();
    check_eq("load_done pulse", 32'(bus1.load_done), 32'd1);
    check_eq("prog_len", 32'(bus1.prog_len), 32'(len1));
    check_eq("load_err clean", 32'(bus1.load_err), 32'd0);
    check_eq("load_ready in COMMIT", 32'(bus1.load_ready), 32'd0);
    check_eq("fetch stalled in COMMIT", 32'(bus1.fetch_valid), 32'd0);
    tick();
    check_eq("load_done one cycle", 32'(bus1.load_done), 32'd0);
  endtask

  initial begin
    logic [7:0] w [$];
    logic [7:0] d2 [5];
    bus1.load_start = 0; bus1.load_valid = 0; bus1.load_data = 0; bus1.load_last = 0;
    bus1.fetch_en = 0; bus1.fetch_addr = 0;
    bus2.load_start = 0; bus2.load_valid = 0; bus2.load_data = 0; bus2.load_last = 0;
    bus2.fetch_en = 0; bus2.fetch_addr = 0;
    exp_instr1[0] = 8'd0;
    exp_instr1[1] = 8'd0;
    for (int i = 0; i < 256; i++) bad1[i] = 1'b0;

    #12;
    check_eq("rst load_ready", 32'(bus1.load_ready), 32'd0);
    check_eq("rst load_done", 32'(bus1.load_done), 32'd0);
    check_eq("rst load_err", 32'(bus1.load_err), 32'd0);
    check_eq("rst prog_len", 32'(bus1.prog_len), 32'd0);
    check_eq("rst fetch_valid", 32'(bus1.fetch_valid), 32'd0);
    check_eq("rst fetch_instr", 32'(bus1.fetch_instr), 32'd0);
    check_eq("rst parity_err", 32'(bus1.parity_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // empty program: everything is NOP
    fetch1(2'b11, 8'd0, 8'd200);

    w = '{8'd0, 8'd5, 8'd28};
    load1(w, 1'b0);
    fetch1(2'b11, 8'd1, 8'd1);
    fetch1(2'b11, 8'd3, 8'd3);
    fetch1(2'b01, 8'd2, 8'd0);
    fetch1(2'b10, 8'd0, 8'd0);
    rand_fetch1(40);

    w = {};
    for (int i = 0; i < 4; i++) w.push_back(8'($urandom));
    load1(w, 1'b1);
    rand_fetch1(40);

`ifdef IMEM_PARITY_EN
    dut1.mem[1][0] = ~dut1.mem[1][0];
    mem1[1][0] = ~mem1[1][0];
    bad1[1] = 1'b1;
    fetch1(2'b11, 8'd1, 8'd1);
    fetch1(2'b11, 8'd2, 8'd1);
`endif

    // AW=2 instance: 5-word stream without last overflows after the 4th word
    for (int i = 0; i < 5; i++) d2[i] = 8'($urandom);
    bus2.load_start = 1'b1;
    tick();
    bus2.load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus2.load_valid = 1'b1;
      bus2.load_data  = d2[i];
      check_eq($sformatf("ovf load_ready beat%0d", i), 32'(bus2.load_ready), 32'(i < 4));
      tick();
      if (i == 3) begin
        check_eq("ovf load_done", 32'(bus2.load_done), 32'd1);
        check_eq("ovf load_err", 32'(bus2.load_err), 32'd1);
        check_eq("ovf prog_len", 32'(bus2.prog_len), 32'd4);
      end
    end
    bus2.load_valid = 1'b0;
    check_eq("ovf idle load_ready", 32'(bus2.load_ready), 32'd0);
    check_eq("ovf done cleared", 32'(bus2.load_done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus2.fetch_en   = 2'b11;
      bus2.fetch_addr = {2'(3 - i), 2'(i)};
      tick();
      check_eq($sformatf("ovf p0 a=%0d", i), 32'(bus2.fetch_instr[7:0]), 32'(d2[i]));
      check_eq($sformatf("ovf p1 a=%0d", 3 - i), 32'(bus2.fetch_instr[15:8]), 32'(d2[3 - i]));
      check_eq("ovf valid", 32'(bus2.fetch_valid), 32'd3);
    end
    bus2.fetch_en = 2'b00;
    check_eq("ovf load_err sticky", 32'(bus2.load_err), 32'd1);

    // reset in the middle of a load
    bus1.load_start = 1'b1;
    tick();
    bus1.load_start = 1'b0;
    bus1.load_valid = 1'b1;
    bus1.load_data  = 8'h77;
    tick();
    tick();
    rst = 1'b1;
    #2;
    check_eq("midrst prog_len", 32'(bus1.prog_len), 32'd0);
    check_eq("midrst load_ready", 32'(bus1.load_ready), 32'd0);
    check_eq("midrst fetch_instr", 32'(bus1.fetch_instr), 32'd0);
    bus1.load_valid = 1'b0;
    len1 = 0;
    exp_instr1[0] = 8'd0;
    exp_instr1[1] = 8'd0;
    tick();
    rst = 1'b0;
    tick();
    check_eq("after rst load_ready", 32'(bus1.load_ready), 32'd0);
    fetch1(2'b11, 8'd0, 8'd1);
    rand_fetch1(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
